pipelined_barrel_shifter: RTL

Parametrised, pipelined multi-function barrel shifter: WIDTH-bit data, runtime-selected rotate/shift mode and direction, one log2 stage per pipeline register, with valid/ready flow control on both sides. Successor to the 8-bit combinational rotate unit. Sits between an upstream producer and a downstream consumer in the datapath, with full backpressure support and one result per cycle at full throughput.

---
 rtl/barrel_pkg.sv | 14 +
 rtl/barrel_stage.sv | 64 ++++++
 rtl/pipelined_barrel_shifter.sv | 63 ++++++
 3 files changed

// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encoding
// and op-field width.
package barrel_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ROR = 2'b00,
        OP_ROL = 2'b01,
        OP_SHR = 2'b10,
        OP_SHL = 2'b11
    } op_t;

endpackage

// File: rtl/barrel_stage.sv
// One registered power-of-two step of the barrel shifter, with its own valid
// bit and ready. SHR fill follows BARREL_ARITH_EN (sign fill when defined).
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_valid,
    input  logic [WIDTH-1:0]         up_data,
    input  logic [$clog2(WIDTH)-1:0] up_amt,
    input  op_t                      up_op,
    input  logic                     down_ready,
    output logic                     ready,
    output logic                     valid,
    output logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] amt,
    output op_t                      op
);

    localparam int unsigned BIT = $clog2(SHIFT);

    logic [WIDTH-1:0] stepped;

    // An empty stage always accepts, so bubbles collapse under a stall.
    assign ready = ~valid | down_ready;

    always_comb begin
        stepped = up_data;
        if (up_amt[BIT]) begin
            unique case (up_op)
                OP_ROR: stepped = (up_data >> SHIFT) | (up_data << (WIDTH - SHIFT));
                OP_ROL: stepped = (up_data << SHIFT) | (up_data >> (WIDTH - SHIFT));
`ifdef BARREL_ARITH_EN
                // MSB stays the original sign bit through every earlier stage.
                OP_SHR: stepped = WIDTH'($signed(up_data) >>> SHIFT);
`else
                OP_SHR: stepped = up_data >> SHIFT;
`endif
                OP_SHL: stepped = up_data << SHIFT;
                default: stepped = up_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            op    <= OP_ROR;
        end else if (ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= stepped;
                amt  <= up_amt;
                op   <= up_op;
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit, one log2 step per register stage, with
// valid/ready flow control. Define BARREL_ARITH_EN for arithmetic SHR.
module pipelined_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned STAGES = AMT_W;

    // Index k is the input side of stage k; index STAGES is the output side.
    logic             valid_c [STAGES+1];
    logic             ready_c [STAGES+1];
    logic [WIDTH-1:0] data_c  [STAGES+1];
    logic [AMT_W-1:0] amt_c   [STAGES+1];
    op_t              op_c    [STAGES+1];

    assign valid_c[0]      = in_valid;
    assign data_c[0]       = in_data;
    assign amt_c[0]        = in_amt;
    assign op_c[0]         = op_t'(in_op);
    assign ready_c[STAGES] = out_ready;
    assign in_ready        = ready_c[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (valid_c[k]),
            .up_data    (data_c[k]),
            .up_amt     (amt_c[k]),
            .up_op      (op_c[k]),
            .down_ready (ready_c[k+1]),
            .ready      (ready_c[k]),
            .valid      (valid_c[k+1]),
            .data       (data_c[k+1]),
            .amt        (amt_c[k+1]),
            .op         (op_c[k+1])
        );
    end

    assign out_valid = valid_c[STAGES];
    assign out_data  = data_c[STAGES];

    logic unused_tail;
    assign unused_tail = ^{amt_c[STAGES], op_c[STAGES]};

endmodule
